// File: rtl/enigma_step_ctrl.sv
// enigma_step_ctrl
// Stepping controller and input stage for the cipher datapath.
// Takes one 8-bit symbol per valid/ready handshake and steps three 2-bit
// rotors odometer-style. The symbol is then registered together with the
// post-step rotor selects, so the downstream barrel/rebarrel mux stages see
// a stable symbol and select set for each character. A start key can be
// loaded synchronously, and accepted characters are counted.

module enigma_step_ctrl #(
    parameter logic [1:0]  NOTCH0 = 2'd3,
    parameter logic [1:0]  NOTCH1 = 2'd3,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [5:0]       load_pos,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:7]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:7]       out_data,
    output logic [5:0]       out_sel,
    output logic [CNT_W-1:0] char_count,
    output logic [5:0]       pos
);

    // Rotor state is packed {r2, r1, r0}, which is also the out_sel layout.
    logic [5:0]       pos_r;
    logic [5:0]       pos_next_s;
    logic             out_valid_r;
    logic [0:7]       out_data_r;
    logic [5:0]       out_sel_r;
    logic [CNT_W-1:0] char_count_r;
    logic             in_ready_s;
    logic             accept_s;
    logic             drain_s;

    // One odometer step. r1 moves only on a carry out of r0, and r2 moves
    // only on a carry out of r1, so no rotor can step twice.
    function automatic logic [5:0] step_pos(input logic [5:0] cur);
        logic       c1;
        logic       c2;
        logic [1:0] n0;
        logic [1:0] n1;
        logic [1:0] n2;
        c1 = (cur[1:0] == NOTCH0);
        c2 = c1 && (cur[3:2] == NOTCH1);
        n0 = cur[1:0] + 2'd1;
        n1 = c1 ? (cur[3:2] + 2'd1) : cur[3:2];
        n2 = c2 ? (cur[5:4] + 2'd1) : cur[5:4];
        return {n2, n1, n0};
    endfunction

    // Handshake decode. Load blocks intake, and a stalled output register
    // blocks intake too, so the rotors never step under backpressure.
    always_comb begin
        in_ready_s = 1'b0;
        accept_s   = 1'b0;
        drain_s    = 1'b0;
        pos_next_s = step_pos(pos_r);
        if (!load && (!out_valid_r || out_ready)) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s = in_valid && in_ready_s;
        drain_s  = out_valid_r && out_ready;
    end

    // Rotor positions: a key load wins; otherwise step only on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_r <= 6'd0;
        end else if (load) begin
            pos_r <= load_pos;
        end else if (accept_s) begin
            pos_r <= pos_next_s;
        end else begin
            pos_r <= pos_r;
        end
    end

    // One-entry output register. Data and select hold their values after a drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= 8'd0;
            out_sel_r   <= 6'd0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= in_data;
            out_sel_r   <= pos_next_s;
        end else if (drain_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Character counter. A key load clears it, and it wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            char_count_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            char_count_r <= char_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            char_count_r <= char_count_r;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign out_sel    = out_sel_r;
    assign char_count = char_count_r;
    assign pos        = pos_r;

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// Directed testbench for enigma_step_ctrl. dut_a uses the default notches,
// and dut_b uses NOTCH0=1. Both instances share the same stimulus.

module tb_enigma_step_ctrl;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [5:0]  load_pos;
    logic        in_valid;
    logic [0:7]  in_data;
    logic        out_ready;

    logic        a_in_ready;
    logic        a_out_valid;
    logic [0:7]  a_out_data;
    logic [5:0]  a_out_sel;
    logic [15:0] a_char_count;
    logic [5:0]  a_pos;

    logic        b_in_ready;
    logic        b_out_valid;
    logic [0:7]  b_out_data;
    logic [5:0]  b_out_sel;
    logic [15:0] b_char_count;
    logic [5:0]  b_pos;

    int vec_cnt;
    int err_cnt;

    logic [5:0] sel_tab [0:3];

    enigma_step_ctrl dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_pos   (load_pos),
        .in_valid   (in_valid),
        .in_ready   (a_in_ready),
        .in_data    (in_data),
        .out_valid  (a_out_valid),
        .out_ready  (out_ready),
        .out_data   (a_out_data),
        .out_sel    (a_out_sel),
        .char_count (a_char_count),
        .pos        (a_pos)
    );

    enigma_step_ctrl #(.NOTCH0(2'd1)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_pos   (load_pos),
        .in_valid   (in_valid),
        .in_ready   (b_in_ready),
        .in_data    (in_data),
        .out_valid  (b_out_valid),
        .out_ready  (out_ready),
        .out_data   (b_out_data),
        .out_sel    (b_out_sel),
        .char_count (b_char_count),
        .pos        (b_pos)
    );

    // Free-running clock; rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt = vec_cnt + 1;
        if (obs !== exp) begin
            err_cnt = err_cnt + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        load      = 1'b0;
        load_pos  = 6'd0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        sel_tab[0] = 6'h01;
        sel_tab[1] = 6'h02;
        sel_tab[2] = 6'h03;
        sel_tab[3] = 6'h04;

        // Reset state
        do_reset();
        #1;
        chk("rst_pos",       {26'd0, a_pos},        32'h0);
        chk("rst_out_valid", {31'd0, a_out_valid},  32'h0);
        chk("rst_out_data",  {24'd0, a_out_data},   32'h0);
        chk("rst_out_sel",   {26'd0, a_out_sel},    32'h0);
        chk("rst_char_count",{16'd0, a_char_count}, 32'h0);
        chk("rst_in_ready",  {31'd0, a_in_ready},   32'h1);

        // Four back-to-back symbols 8'h41..8'h44
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h41 + i[7:0];
            @(negedge clk);
            chk("b2b_valid", {31'd0, a_out_valid}, 32'h1);
            chk("b2b_data",  {24'd0, a_out_data},  32'h41 + i);
            chk("b2b_sel",   {26'd0, a_out_sel},   {26'd0, sel_tab[i]});
            if (i == 1) begin
                chk("notch0_1_sel", {26'd0, b_out_sel}, 32'h06);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain_valid", {31'd0, a_out_valid},  32'h0);
        chk("drain_sel",   {26'd0, a_out_sel},    32'h04);
        chk("drain_count", {16'd0, a_char_count}, 32'h4);

        // 64 accepts from reset: full wrap of all three rotors
        do_reset();
        in_valid = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            in_data = k[7:0];
            @(negedge clk);
            if (k == 16) begin
                chk("acc16_sel", {26'd0, a_out_sel}, 32'h10);
            end
            if (k == 64) begin
                chk("acc64_sel",   {26'd0, a_out_sel},    32'h00);
                chk("acc64_pos",   {26'd0, a_pos},        32'h00);
                chk("acc64_count", {16'd0, a_char_count}, 32'd64);
            end
        end
        in_valid = 1'b0;

        // Key load with a simultaneous offer: no accept that cycle
        load     = 1'b1;
        load_pos = 6'h3F;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        #1;
        chk("load_in_ready", {31'd0, a_in_ready}, 32'h0);
        @(negedge clk);
        chk("load_pos",   {26'd0, a_pos},        32'h3F);
        chk("load_count", {16'd0, a_char_count}, 32'h0);
        load = 1'b0;
        @(negedge clk);
        chk("after_load_sel",   {26'd0, a_out_sel},    32'h00);
        chk("after_load_data",  {24'd0, a_out_data},   32'hAA);
        chk("after_load_count", {16'd0, a_char_count}, 32'h1);

        // Backpressure for 5 cycles, then accept and drain together
        out_ready = 1'b0;
        in_data   = 8'hBB;
        #1;
        chk("bp_in_ready", {31'd0, a_in_ready}, 32'h0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid",    {31'd0, a_out_valid}, 32'h1);
            chk("bp_data",     {24'd0, a_out_data},  32'hAA);
            chk("bp_sel",      {26'd0, a_out_sel},   32'h00);
            chk("bp_pos",      {26'd0, a_pos},       32'h00);
            chk("bp_in_ready", {31'd0, a_in_ready},  32'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("rel_in_ready", {31'd0, a_in_ready}, 32'h1);
        @(negedge clk);
        chk("rel_valid", {31'd0, a_out_valid},  32'h1);
        chk("rel_data",  {24'd0, a_out_data},   32'hBB);
        chk("rel_sel",   {26'd0, a_out_sel},    32'h01);
        chk("rel_count", {16'd0, a_char_count}, 32'h2);

        // Asynchronous reset between edges while an entry is buffered
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("pre_arst_valid", {31'd0, a_out_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, a_out_valid},  32'h0);
        chk("arst_pos",   {26'd0, a_pos},        32'h0);
        chk("arst_count", {16'd0, a_char_count}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
